// File: rtl/cpu_core_w_pkg.sv
// Shared definitions for the width-parametrised core.
// Holds the FSM state codes, instruction field encodings (direction, ALU op,
// branch condition, register select) used by the core and its ALU.
package cpu_core_w_pkg;

  typedef enum logic [2:0] {
    StBoot  = 3'd0,
    StFetch = 3'd1,
    StExec  = 3'd2,
    StLoad  = 3'd3,
    StStore = 3'd4,
    StHalt  = 3'd5
  } state_e;

  // Instruction [7:6]
  typedef enum logic [1:0] {
    DirReg    = 2'b00,
    DirLoad   = 2'b01,
    DirStore  = 2'b10,
    DirBranch = 2'b11
  } dir_e;

  // Instruction [5:4] for register, load and store instructions
  typedef enum logic [1:0] {
    OpMov  = 2'b00,
    OpAdd  = 2'b01,
    OpSub  = 2'b10,
    OpTest = 2'b11
  } alu_op_e;

  // Instruction [5:4] reinterpreted for branch instructions
  typedef enum logic [1:0] {
    BrAlways  = 2'b00,
    BrZero    = 2'b01,
    BrNotZero = 2'b10,
    BrHalt    = 2'b11
  } br_op_e;

  // Instruction [3:2] (A) and [1:0] (B)
  typedef enum logic [1:0] {
    RegR0 = 2'b00,
    RegR1 = 2'b01,
    RegR2 = 2'b10,
    RegIp = 2'b11
  } reg_sel_e;

endpackage

// File: rtl/alu_w.sv
// Combinational ALU: mov / add / sub / test, all modulo 2^DATA_W.
// Ports:
//   op     - ALU operation
//   a, b   - operands (b is rB or the loaded bus word)
//   result - operation result (test passes a through; it is never written back)
//   zero   - zero flag candidate: result==0, or b==0 for test
module alu_w
  import cpu_core_w_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = b;
    unique case (op)
      OpMov:  result = b;
      OpAdd:  result = a + b;
      OpSub:  result = a - b;
      OpTest: result = a;
      default: result = b;
    endcase
  end

  assign zero = (op == OpTest) ? (b == '0) : (result == '0);

endmodule

// File: rtl/cpu_core_w.sv
// Multi-cycle 8-bit-instruction CPU core with generic data width.
// One shared address space for memory and peripherals; every bus cycle is
// held until ready. Instruction word bits [7:0] are decoded, upper bits ignored.
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-high reset
//   address  - bus address (address buffer register)
//   data_in  - read data, sampled when read && ready
//   data_out - write data (data buffer register)
//   ready    - completes the current read or write cycle
//   read     - read request (fetch and load)
//   write    - write request (store)
//   halted   - core stopped by a halt instruction
module cpu_core_w
  import cpu_core_w_pkg::*;
#(
  parameter int unsigned      DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              ready,
  output logic              read,
  output logic              write,
  output logic              halted
);

  state_e            state_q;
  logic [DATA_W-1:0] ip_q, r0_q, r1_q, r2_q;
  logic [DATA_W-1:0] addr_buf_q, data_buf_q;
  logic              z_q;
  logic [7:0]        cmd_q;
  logic              read_q, write_q, halted_q;

  dir_e     dir;
  alu_op_e  op;
  br_op_e   br_op;
  reg_sel_e sel_a, sel_b;

  assign dir   = dir_e'(cmd_q[7:6]);
  assign op    = alu_op_e'(cmd_q[5:4]);
  assign br_op = br_op_e'(cmd_q[5:4]);
  assign sel_a = reg_sel_e'(cmd_q[3:2]);
  assign sel_b = reg_sel_e'(cmd_q[1:0]);

  logic [DATA_W-1:0] ra_val, rb_val, alu_b, alu_res, ip_inc;
  logic [DATA_W-1:0] exec_ip, load_ip;
  logic              alu_zero, writes_reg, br_taken, reg_we;

  always_comb begin
    ra_val = r0_q;
    unique case (sel_a)
      RegR0: ra_val = r0_q;
      RegR1: ra_val = r1_q;
      RegR2: ra_val = r2_q;
      RegIp: ra_val = ip_q;
      default: ra_val = r0_q;
    endcase
  end

  always_comb begin
    rb_val = r0_q;
    unique case (sel_b)
      RegR0: rb_val = r0_q;
      RegR1: rb_val = r1_q;
      RegR2: rb_val = r2_q;
      RegIp: rb_val = ip_q;
      default: rb_val = r0_q;
    endcase
  end

  // Single ALU: operand B is the bus word while a load completes.
  assign alu_b = (state_q == StLoad) ? data_in : rb_val;

  alu_w #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op    (op),
    .a     (ra_val),
    .b     (alu_b),
    .result(alu_res),
    .zero  (alu_zero)
  );

  assign writes_reg = (op != OpTest);
  assign ip_inc     = ip_q + DATA_W'(1);

  always_comb begin
    br_taken = 1'b0;
    unique case (br_op)
      BrAlways:  br_taken = 1'b1;
      BrZero:    br_taken = z_q;
      BrNotZero: br_taken = ~z_q;
      BrHalt:    br_taken = 1'b0;
      default:   br_taken = 1'b0;
    endcase
  end

  // ip after a register or branch instruction (ip_q is already incremented).
  always_comb begin
    exec_ip = ip_q;
    if (dir == DirReg && sel_a == RegIp && writes_reg) begin
      exec_ip = alu_res;
    end else if (dir == DirBranch && br_taken) begin
      exec_ip = rb_val;
    end
  end

  // ip after a load: skip the immediate word, unless ip itself is the target.
  always_comb begin
    load_ip = (sel_b == RegIp) ? ip_inc : ip_q;
    if (sel_a == RegIp && writes_reg) begin
      load_ip = alu_res;
    end
  end

  assign reg_we = writes_reg &&
                  ((state_q == StExec && dir == DirReg) || (state_q == StLoad && ready));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StBoot;
      ip_q       <= RESET_VEC;
      r0_q       <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
      z_q        <= 1'b0;
      cmd_q      <= '0;
      addr_buf_q <= RESET_VEC;
      data_buf_q <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StBoot: begin
          addr_buf_q <= ip_q;
          read_q     <= 1'b1;
          state_q    <= StFetch;
        end
        StFetch: begin
          if (ready) begin
            cmd_q   <= data_in[7:0];
            ip_q    <= ip_inc;
            read_q  <= 1'b0;
            state_q <= StExec;
          end
        end
        StExec: begin
          unique case (dir)
            DirReg: begin
              if (op != OpMov) z_q <= alu_zero;
              ip_q       <= exec_ip;
              addr_buf_q <= exec_ip;
              read_q     <= 1'b1;
              state_q    <= StFetch;
            end
            DirLoad: begin
              addr_buf_q <= rb_val;
              read_q     <= 1'b1;
              state_q    <= StLoad;
            end
            DirStore: begin
              addr_buf_q <= rb_val;
              data_buf_q <= ra_val;
              write_q    <= 1'b1;
              state_q    <= StStore;
            end
            DirBranch: begin
              if (br_op == BrHalt) begin
                halted_q <= 1'b1;
                state_q  <= StHalt;
              end else begin
                ip_q       <= exec_ip;
                addr_buf_q <= exec_ip;
                read_q     <= 1'b1;
                state_q    <= StFetch;
              end
            end
            default: state_q <= StFetch;
          endcase
        end
        StLoad: begin
          if (ready) begin
            if (op != OpMov) z_q <= alu_zero;
            ip_q       <= load_ip;
            addr_buf_q <= load_ip;
            state_q    <= StFetch;
          end
        end
        StStore: begin
          if (ready) begin
            write_q    <= 1'b0;
            read_q     <= 1'b1;
            addr_buf_q <= ip_q;
            state_q    <= StFetch;
          end
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          read_q   <= 1'b0;
          write_q  <= 1'b0;
          halted_q <= 1'b0;
          state_q  <= StBoot;
        end
      endcase

      // ip as destination is handled by the FSM above.
      if (reg_we) begin
        unique case (sel_a)
          RegR0: r0_q <= alu_res;
          RegR1: r1_q <= alu_res;
          RegR2: r2_q <= alu_res;
          default: ;
        endcase
      end
    end
  end

  assign address  = addr_buf_q;
  assign data_out = data_buf_q;
  assign read     = read_q;
  assign write    = write_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_cpu_core_w.sv
// Bench for cpu_core_w: an 8-bit and a 16-bit instance, each with its own
// memory model. Expected bus cycles (kind, address, write data, cycle number
// since reset release) are queued per test and popped by a bus monitor.
module tb_cpu_core_w;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } bus_t;

  logic clk;
  logic reset8, reset16, ready8, ready16;
  logic [7:0]  addr8, din8, dout8;
  logic [15:0] addr16, din16, dout16;
  logic rd8, wr8, hlt8, rd16, wr16, hlt16;

  logic [7:0]  mem8 [256];
  logic [15:0] mem16 [1024];
  bus_t q8[$];
  bus_t q16[$];
  bus_t m8_e, m16_e;
  int cyc8, cyc16;
  int n_chk, n_err;

  assign din8  = mem8[addr8];
  assign din16 = mem16[addr16[9:0]];

  cpu_core_w #(
    .DATA_W   (8),
    .RESET_VEC(8'h00)
  ) dut8 (
    .clk     (clk),
    .reset   (reset8),
    .address (addr8),
    .data_in (din8),
    .data_out(dout8),
    .ready   (ready8),
    .read    (rd8),
    .write   (wr8),
    .halted  (hlt8)
  );

  cpu_core_w #(
    .DATA_W   (16),
    .RESET_VEC(16'h0100)
  ) dut16 (
    .clk     (clk),
    .reset   (reset16),
    .address (addr16),
    .data_in (din16),
    .data_out(dout16),
    .ready   (ready16),
    .read    (rd16),
    .write   (wr16),
    .halted  (hlt16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset8) begin
    if (reset8) cyc8 <= 0;
    else        cyc8 <= cyc8 + 1;
  end

  always @(posedge clk or posedge reset16) begin
    if (reset16) cyc16 <= 0;
    else         cyc16 <= cyc16 + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push8(input logic wr, input int addr, input int data, input int cyc);
    bus_t e;
    e.wr = wr; e.addr = addr[15:0]; e.data = data[15:0]; e.cyc = cyc;
    q8.push_back(e);
  endtask

  task automatic push16(input logic wr, input int addr, input int data, input int cyc);
    bus_t e;
    e.wr = wr; e.addr = addr[15:0]; e.data = data[15:0]; e.cyc = cyc;
    q16.push_back(e);
  endtask

  // A bus cycle completes at the next rising edge; sample on the falling one.
  always @(negedge clk) begin
    if (!reset8 && ready8 && (rd8 || wr8)) begin
      if (q8.size() == 0) begin
        check_eq("bus8_unexpected", q8.size(), 1);
      end else begin
        m8_e = q8.pop_front();
        check_eq("bus8_kind", wr8, m8_e.wr);
        check_eq("bus8_addr", addr8, m8_e.addr);
        check_eq("bus8_cyc", cyc8, m8_e.cyc);
        if (m8_e.wr) check_eq("bus8_data", dout8, m8_e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset16 && ready16 && (rd16 || wr16)) begin
      if (q16.size() == 0) begin
        check_eq("bus16_unexpected", q16.size(), 1);
      end else begin
        m16_e = q16.pop_front();
        check_eq("bus16_kind", wr16, m16_e.wr);
        check_eq("bus16_addr", addr16, m16_e.addr);
        check_eq("bus16_cyc", cyc16, m16_e.cyc);
        if (m16_e.wr) check_eq("bus16_data", dout16, m16_e.data);
      end
    end
  end

  task automatic start8();
    reset8 = 1'b1;
    ready8 = 1'b1;
    q8.delete();
    for (int i = 0; i < 256; i++) mem8[i] = 8'hF0;
  endtask

  task automatic release8();
    @(posedge clk);
    #1 reset8 = 1'b0;
  endtask

  task automatic wait_done8(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q8.size() == 0 && hlt8) break;
      @(posedge clk);
      #1;
    end
    check_eq("done8_pending", q8.size(), 0);
    check_eq("done8_halted", hlt8, 1'b1);
    q8.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    reset16 = 1'b1;
    ready16 = 1'b1;

    // Reset state, boot cycle, fetch hold and asynchronous reset mid-fetch.
    start8();
    #1;
    check_eq("rst_read", rd8, 1'b0);
    check_eq("rst_write", wr8, 1'b0);
    check_eq("rst_halted", hlt8, 1'b0);
    check_eq("rst_addr", addr8, 8'h00);
    release8();
    @(negedge clk);
    check_eq("boot_read", rd8, 1'b0);
    ready8 = 1'b0;
    @(posedge clk);
    #1;
    check_eq("fetch_read", rd8, 1'b1);
    check_eq("fetch_addr", addr8, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check_eq("fetch_hold_read", rd8, 1'b1);
    check_eq("fetch_hold_addr", addr8, 8'h00);
    #2 reset8 = 1'b1;
    #1;
    check_eq("async_rst_read", rd8, 1'b0);
    ready8 = 1'b1;
    push8(0, 8'h00, 0, 1);
    release8();
    wait_done8(100);

    // Immediate loads, add to zero, branch taken on Z, store result.
    start8();
    mem8[0] = 8'h43; mem8[1] = 8'h5A; mem8[2] = 8'h47; mem8[3] = 8'hA6;
    mem8[4] = 8'h11; mem8[5] = 8'hD1; mem8[8'hA6] = 8'h81; mem8[8'hA7] = 8'hF0;
    push8(0, 8'h00, 0, 1);  push8(0, 8'h01, 0, 3);  push8(0, 8'h02, 0, 4);
    push8(0, 8'h03, 0, 6);  push8(0, 8'h04, 0, 7);  push8(0, 8'h05, 0, 9);
    push8(0, 8'hA6, 0, 11); push8(1, 8'hA6, 8'h00, 13); push8(0, 8'hA7, 0, 14);
    release8();
    wait_done8(100);

    // Same with r1=A5: result nonzero, branch falls through.
    start8();
    mem8[0] = 8'h43; mem8[1] = 8'h5A; mem8[2] = 8'h47; mem8[3] = 8'hA5;
    mem8[4] = 8'h11; mem8[5] = 8'hD1; mem8[6] = 8'h81; mem8[7] = 8'hF0;
    push8(0, 8'h00, 0, 1);  push8(0, 8'h01, 0, 3);  push8(0, 8'h02, 0, 4);
    push8(0, 8'h03, 0, 6);  push8(0, 8'h04, 0, 7);  push8(0, 8'h05, 0, 9);
    push8(0, 8'h06, 0, 11); push8(1, 8'hA5, 8'hFF, 13); push8(0, 8'h07, 0, 14);
    release8();
    wait_done8(100);

    // Store with three wait states.
    start8();
    mem8[0] = 8'h43; mem8[1] = 8'h33; mem8[2] = 8'h47; mem8[3] = 8'h80;
    mem8[4] = 8'h81; mem8[5] = 8'hF0;
    push8(0, 8'h00, 0, 1); push8(0, 8'h01, 0, 3); push8(0, 8'h02, 0, 4);
    push8(0, 8'h03, 0, 6); push8(0, 8'h04, 0, 7); push8(1, 8'h80, 8'h33, 12);
    push8(0, 8'h05, 0, 13);
    release8();
    for (int i = 0; i < 50 && !wr8; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("store_seen", wr8, 1'b1);
    check_eq("store_cyc", cyc8, 9);
    ready8 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("wait_write", wr8, 1'b1);
      check_eq("wait_addr", addr8, 8'h80);
      check_eq("wait_data", dout8, 8'h33);
      if (k < 3) begin
        @(posedge clk);
        #1;
        if (k == 2) ready8 = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_eq("post_store_read", rd8, 1'b1);
    check_eq("post_store_addr", addr8, 8'h05);
    wait_done8(100);

    // Halt: quiet bus for 20 cycles, reset restarts at the reset vector.
    start8();
    push8(0, 8'h00, 0, 1);
    release8();
    wait_done8(100);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_eq("halt_quiet", {hlt8, rd8, wr8}, 3'b100);
    end
    reset8 = 1'b1;
    #1;
    check_eq("halt_rst", hlt8, 1'b0);
    push8(0, 8'h00, 0, 1);
    release8();
    wait_done8(100);

    // 16-bit core at reset vector 0x0100; upper instruction bits ignored.
    for (int i = 0; i < 1024; i++) mem16[i] = 16'h00F0;
    mem16[16'h100] = 16'h004B; mem16[16'h101] = 16'hFFFF;
    mem16[16'h102] = 16'hAB47; mem16[16'h103] = 16'h0001;
    mem16[16'h104] = 16'h0019; mem16[16'h105] = 16'hAB43;
    mem16[16'h106] = 16'h1234; mem16[16'h107] = 16'h55D2;
    mem16[16'h000] = 16'h0082;
    #1;
    check_eq("rst16_addr", addr16, 16'h0100);
    push16(0, 16'h100, 0, 1);  push16(0, 16'h101, 0, 3);  push16(0, 16'h102, 0, 4);
    push16(0, 16'h103, 0, 6);  push16(0, 16'h104, 0, 7);  push16(0, 16'h105, 0, 9);
    push16(0, 16'h106, 0, 11); push16(0, 16'h107, 0, 12); push16(0, 16'h000, 0, 14);
    push16(1, 16'h000, 16'h1234, 16); push16(0, 16'h001, 0, 17);
    @(posedge clk);
    #1 reset16 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (q16.size() == 0 && hlt16) break;
      @(posedge clk);
      #1;
    end
    check_eq("done16_pending", q16.size(), 0);
    check_eq("done16_halted", hlt16, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
